io_out_fifo: RTL

- Buffered output port downstream of the processor's store-to-0xFF path. The processor drives `wr_en` from `mem_write && alu_result == 8'hFF`, and `wr_data` from `read_data2`.
- Queues each output byte in a small FIFO.
- Presents bytes to an external consumer (LED driver, UART TX) on a valid/ready stream, so no processor store is lost when the consumer stalls.
- Reports full/empty/count status and a sticky overflow flag.

---
 rtl/risc_pkg.sv | 14 +
 rtl/io_fifo_storage.sv | 26 ++
 rtl/io_out_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared processor constants: the memory-mapped output port address and
// the default geometry of the output FIFO that sits behind it.
package risc_pkg;

  localparam logic [7:0] IO_PORT_ADDR  = 8'hFF;
  localparam int         DATA_W        = 8;
  localparam int         IO_FIFO_DEPTH = 4;

  // Pointer wrap relies on plain binary rollover, so depth must be 2^n.
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/io_fifo_storage.sv
// Register array for the output FIFO: synchronous write port and
// asynchronous read port so the head byte falls through without a read cycle.
module io_fifo_storage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/io_out_fifo.sv
// Buffered output port for stores to the I/O address: queues bytes and hands
// them to an external consumer over valid/ready, flagging any dropped push.
module io_out_fifo #(
  parameter  int DATA_W = risc_pkg::DATA_W,
  parameter  int DEPTH  = risc_pkg::IO_FIFO_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  import risc_pkg::*;

  localparam int AW = $clog2(DEPTH);

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("io_out_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] w_rdata;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;

  io_fifo_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_storage (
    .clk   (clk),
    .we    (w_push_ok),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // Flags come from the registered count; pointers alone cannot tell full from empty.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && out_ready;
  assign w_push_ok = wr_en && (!w_full || w_pop);
  assign w_drop    = wr_en && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
      // A drop in the same cycle as a clear must still leave the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rdata;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule
